sem_cmd_arb: RTL and testbench
==============================

Name: sem_cmd_arb

Overview:
- Parametrised successor to the single-requester SEM command handshake.
- Arbitrates NCH independent command requesters onto one SEM controller command interface using round-robin ordering.
- Each requester uses a level SEND with per-channel re-arm. A command word is captured at grant.
- The block adds an ACK timeout with per-channel error flags and per-channel completion pulses.

Parameters:
NCH, 4, number of requesting channels (1..16)
CMD_W, 8, command word width per channel
TMO_W, 16, timeout counter width
TIMEOUT, 1000, cycles to wait for ACK while READY; 0 disables the timeout

Ports:
CLK  in  1  clock; all logic rising-edge
RST  in  1  reset, asynchronous, active-high
SEND  in  NCH  per-channel request level
CMD  in  NCH*CMD_W  per-channel command word; channel i occupies bits [i*CMD_W +: CMD_W]
ACK  in  1  SEM controller accepted the presented command
READY  out  1  command valid toward the SEM controller
CMD_OUT  out  CMD_W  granted command word
CH_SEL  out  max(1,clog2(NCH))  index of the granted channel
DONE  out  NCH  one-cycle pulse on ACK for the served channel
TMO_ERR  out  NCH  sticky timeout flag per channel
SEM_STATE  out  2  current FSM state encoding

Behaviour:
- Reset values:
  - state=IDLE, READY=0, CMD_OUT=0, CH_SEL=0, DONE=0, TMO_ERR=0.
  - armed=all 1; rr pointer "last"=NCH-1, so ch0 has top priority first.
  - Timeout counter=0.
- Per-channel arming:
  - armed[i] sets on any cycle with SEND[i]=0.
  - armed[i] clears when channel i completes (ACK) or times out.
  - req[i] = SEND[i] & armed[i]. A channel holding SEND high after service is not re-served until it drops SEND for at least 1 cycle.
- FSM (registered; encodings IDLE=2'b00, GAP=2'b01, READY=2'b10; SEM_STATE=state):
  - IDLE:
    - If any req, grant the first requesting channel searching last+1, last+2, ... with wrap mod NCH.
    - Register CMD_OUT=CMD[grant], CH_SEL=grant, last=grant.
    - Clear TMO_ERR[grant]; clear counter; go READY.
    - Otherwise stay IDLE.
  - READY:
    - READY=1 (decoded from state, registered). CMD_OUT and CH_SEL are held constant.
    - Counter increments each cycle.
    - ACK=1: DONE[CH_SEL] pulses the next cycle (registered), armed[CH_SEL] clears, go GAP.
    - Else if TIMEOUT!=0 and counter==TIMEOUT-1: TMO_ERR[CH_SEL] sets, armed[CH_SEL] clears, go GAP.
    - ACK and timeout in the same cycle: ACK wins, no error.
  - GAP: READY=0 for exactly one cycle; then IDLE. Guarantees READY deasserts between commands.
- Latency:
  - req rising in cycle n (state IDLE) gives READY=1 from cycle n+1.
  - Back-to-back commands: READY low for minimum 2 cycles (GAP, IDLE).
- Once granted, a command is not withdrawn: SEND or CMD changes during READY are ignored. If SEND drops during READY, the channel re-arms normally after completion.
- ACK outside READY is ignored.
- Counter saturates; width must hold TIMEOUT-1.
- RST mid-transaction: READY drops immediately (asynchronous); no DONE or TMO_ERR is generated.
- NCH=1 degenerates to the single-channel handshake: Idle→Ready on SEND, wait for ACK, wait for SEND low.

Test Plan:
1. Reset, then SEND=4'b0001 with CMD ch0=8'hA5 → READY=1 next cycle, CMD_OUT=A5, CH_SEL=0. ACK after 3 cycles → DONE=4'b0001 for 1 cycle, READY=0. SEND still high → no second READY until SEND drops and rises again.
2. SEND=4'b1111 held and ACK returned 2 cycles after each READY, SEND dropped 1 cycle after each DONE → grant order ch0,ch1,ch2,ch3,ch0. Every READY gap ≥2 cycles.
3. TIMEOUT=20, SEND[2]=1, no ACK → READY held exactly 20 cycles, then TMO_ERR=4'b0100, READY=0. SEND[2] low→high → ch2 re-granted and TMO_ERR[2] clears at grant.
4. ACK asserted on the same cycle the counter reaches TIMEOUT-1 → DONE pulses, TMO_ERR stays 0.
5. SEND[1] dropped and CMD[1] changed mid-READY → CMD_OUT unchanged. ACK still produces DONE[1]. Stray ACK pulses in IDLE produce no DONE.
6. RST asserted during READY → READY, DONE and TMO_ERR go 0 asynchronously. After release, ch0 has priority again.

Source files
------------

// File: rtl/sem_cmd_arb.sv
// Round-robin arbiter funnelling NCH level-SEND command requesters onto one
// SEM controller command handshake, with per-channel ACK timeout and completion flags.
module sem_cmd_arb #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CMD_W   = 8,
  parameter int unsigned TMO_W   = 16,
  parameter int unsigned TIMEOUT = 1000,
  localparam int unsigned SEL_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NCH-1:0]     SEND,
  input  logic [NCH*CMD_W-1:0] CMD,
  input  logic               ACK,
  output logic               READY,
  output logic [CMD_W-1:0]   CMD_OUT,
  output logic [SEL_W-1:0]   CH_SEL,
  output logic [NCH-1:0]     DONE,
  output logic [NCH-1:0]     TMO_ERR,
  output logic [1:0]         SEM_STATE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GAP   = 2'b01,
    S_READY = 2'b10
  } state_t;

  localparam bit              TMO_EN   = (TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NCH-1:0]     r_armed;
  logic [SEL_W-1:0]   r_last;
  logic [CMD_W-1:0]   r_cmd_out;
  logic [SEL_W-1:0]   r_ch_sel;
  logic [NCH-1:0]     r_done;
  logic [NCH-1:0]     r_tmo_err;
  logic [TMO_W-1:0]   r_cnt;

  logic [NCH-1:0]     w_req;
  logic               w_found;
  logic [SEL_W-1:0]   w_grant;
  logic [NCH-1:0]     w_grant_oh;
  logic [CMD_W-1:0]   w_grant_cmd;
  logic [NCH-1:0]     w_sel_oh;
  logic               w_grant_ev;
  logic               w_ack_ev;
  logic               w_tmo_ev;
  int unsigned        w_best;
  int unsigned        w_dist;

  // Rotating priority: distance 0 is the channel just after the last grant.
  always_comb begin
    w_req       = SEND & r_armed;
    w_found     = 1'b0;
    w_grant     = '0;
    w_grant_oh  = '0;
    w_grant_cmd = '0;
    w_best      = NCH;
    w_dist      = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_dist = (i + 2 * NCH - 1 - 32'(r_last)) % NCH;
      if (w_req[i] && (w_dist < w_best)) begin
        w_best      = w_dist;
        w_found     = 1'b1;
        w_grant     = SEL_W'(i);
        w_grant_oh  = '0;
        w_grant_oh[i] = 1'b1;
        w_grant_cmd = CMD[i*CMD_W +: CMD_W];
      end
    end
  end

  always_comb begin
    w_sel_oh = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_sel_oh[i] = (r_ch_sel == SEL_W'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_ev  = 1'b0;
    w_ack_ev    = 1'b0;
    w_tmo_ev    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_ev  = 1'b1;
          w_state_nxt = S_READY;
        end
      end
      S_READY: begin
        if (ACK) begin
          w_ack_ev    = 1'b1;
          w_state_nxt = S_GAP;
        end else if (TMO_EN && (r_cnt == TMO_LAST)) begin
          w_tmo_ev    = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_armed   <= '1;
      r_last    <= SEL_W'(NCH - 1);
      r_cmd_out <= '0;
      r_ch_sel  <= '0;
      r_done    <= '0;
      r_tmo_err <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= '0;
      // Completion clears the arm even if SEND is low that cycle; it re-arms on the next low cycle.
      if (w_ack_ev || w_tmo_ev) begin
        r_armed <= (r_armed | ~SEND) & ~w_sel_oh;
      end else begin
        r_armed <= r_armed | ~SEND;
      end
      if (w_grant_ev) begin
        r_cmd_out <= w_grant_cmd;
        r_ch_sel  <= w_grant;
        r_last    <= w_grant;
        r_tmo_err <= r_tmo_err & ~w_grant_oh;
        r_cnt     <= '0;
      end else if ((r_state == S_READY) && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_ack_ev) begin
        r_done <= w_sel_oh;
      end
      if (w_tmo_ev) begin
        r_tmo_err <= r_tmo_err | w_sel_oh;
      end
    end
  end

  assign READY     = (r_state == S_READY);
  assign CMD_OUT   = r_cmd_out;
  assign CH_SEL    = r_ch_sel;
  assign DONE      = r_done;
  assign TMO_ERR   = r_tmo_err;
  assign SEM_STATE = r_state;

endmodule

// File: tb/tb_sem_cmd_arb.sv
// Directed, table-driven bench for sem_cmd_arb (NCH=4, CMD_W=8, TIMEOUT=20)
// with hand-written sequences for timeout, ACK/timeout collision and async reset.
module tb_sem_cmd_arb;

  logic        CLK;
  logic        RST;
  logic [3:0]  SEND;
  logic [31:0] CMD;
  logic        ACK;
  logic        READY;
  logic [7:0]  CMD_OUT;
  logic [1:0]  CH_SEL;
  logic [3:0]  DONE;
  logic [3:0]  TMO_ERR;
  logic [1:0]  SEM_STATE;

  int n_checks = 0;
  int n_pass   = 0;

  sem_cmd_arb #(
    .NCH(4),
    .CMD_W(8),
    .TMO_W(8),
    .TIMEOUT(20)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .SEND(SEND),
    .CMD(CMD),
    .ACK(ACK),
    .READY(READY),
    .CMD_OUT(CMD_OUT),
    .CH_SEL(CH_SEL),
    .DONE(DONE),
    .TMO_ERR(TMO_ERR),
    .SEM_STATE(SEM_STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        pre_rst;
    logic [3:0]  send;
    logic [31:0] cmd;
    logic        ack;
    logic        exp_ready;
    logic [7:0]  exp_cmd;
    logic [1:0]  exp_sel;
    logic [3:0]  exp_done;
    logic [3:0]  exp_tmo;
    logic [1:0]  exp_st;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST  = 1'b1;
    SEND = '0;
    CMD  = '0;
    ACK  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic rdy, input logic [7:0] c,
                           input logic [1:0] sel, input logic [3:0] dn,
                           input logic [3:0] tm, input logic [1:0] st);
    check({tag, "_ready"}, 32'(READY), 32'(rdy));
    check({tag, "_cmd"},   32'(CMD_OUT), 32'(c));
    check({tag, "_sel"},   32'(CH_SEL), 32'(sel));
    check({tag, "_done"},  32'(DONE), 32'(dn));
    check({tag, "_tmo"},   32'(TMO_ERR), 32'(tm));
    check({tag, "_state"}, 32'(SEM_STATE), 32'(st));
  endtask

  task automatic addv(input logic r, input logic [3:0] s, input logic [31:0] c, input logic a,
                      input logic er, input logic [7:0] ec, input logic [1:0] es,
                      input logic [3:0] ed, input logic [3:0] et, input logic [1:0] est);
    vec_t v;
    v = '{r, s, c, a, er, ec, es, ed, et, est};
    tbl.push_back(v);
  endtask

  initial begin : main
    int cnt;
    logic [31:0] c1;
    logic [31:0] c2;
    RST  = 1'b1;
    SEND = '0;
    CMD  = '0;
    ACK  = 1'b0;
    c1 = 32'h0000_00A5;
    c2 = 32'h4433_2211;

    // Basic handshake and re-arm on ch0
    addv(1, 4'b0001, c1, 0, 1, 8'hA5, 0, 4'b0000, 4'b0000, 2'd2);
    addv(0, 4'b0001, c1, 0, 1, 8'hA5, 0, 4'b0000, 4'b0000, 2'd2);
    addv(0, 4'b0001, c1, 0, 1, 8'hA5, 0, 4'b0000, 4'b0000, 2'd2);
    addv(0, 4'b0001, c1, 1, 0, 8'hA5, 0, 4'b0001, 4'b0000, 2'd1);
    addv(0, 4'b0001, c1, 0, 0, 8'hA5, 0, 4'b0000, 4'b0000, 2'd0);
    addv(0, 4'b0001, c1, 0, 0, 8'hA5, 0, 4'b0000, 4'b0000, 2'd0);
    addv(0, 4'b0000, c1, 0, 0, 8'hA5, 0, 4'b0000, 4'b0000, 2'd0);
    addv(0, 4'b0001, c1, 0, 1, 8'hA5, 0, 4'b0000, 4'b0000, 2'd2);
    addv(0, 4'b0001, c1, 1, 0, 8'hA5, 0, 4'b0001, 4'b0000, 2'd1);
    addv(0, 4'b0000, c1, 0, 0, 8'hA5, 0, 4'b0000, 4'b0000, 2'd0);
    // Round robin over all four channels
    addv(1, 4'b1111, c2, 0, 1, 8'h11, 0, 4'b0000, 4'b0000, 2'd2);
    addv(0, 4'b1111, c2, 0, 1, 8'h11, 0, 4'b0000, 4'b0000, 2'd2);
    addv(0, 4'b1111, c2, 1, 0, 8'h11, 0, 4'b0001, 4'b0000, 2'd1);
    addv(0, 4'b1110, c2, 0, 0, 8'h11, 0, 4'b0000, 4'b0000, 2'd0);
    addv(0, 4'b1111, c2, 0, 1, 8'h22, 1, 4'b0000, 4'b0000, 2'd2);
    addv(0, 4'b1111, c2, 0, 1, 8'h22, 1, 4'b0000, 4'b0000, 2'd2);
    addv(0, 4'b1111, c2, 1, 0, 8'h22, 1, 4'b0010, 4'b0000, 2'd1);
    addv(0, 4'b1101, c2, 0, 0, 8'h22, 1, 4'b0000, 4'b0000, 2'd0);
    addv(0, 4'b1111, c2, 0, 1, 8'h33, 2, 4'b0000, 4'b0000, 2'd2);
    addv(0, 4'b1111, c2, 0, 1, 8'h33, 2, 4'b0000, 4'b0000, 2'd2);
    addv(0, 4'b1111, c2, 1, 0, 8'h33, 2, 4'b0100, 4'b0000, 2'd1);
    addv(0, 4'b1011, c2, 0, 0, 8'h33, 2, 4'b0000, 4'b0000, 2'd0);
    addv(0, 4'b1111, c2, 0, 1, 8'h44, 3, 4'b0000, 4'b0000, 2'd2);
    addv(0, 4'b1111, c2, 0, 1, 8'h44, 3, 4'b0000, 4'b0000, 2'd2);
    addv(0, 4'b1111, c2, 1, 0, 8'h44, 3, 4'b1000, 4'b0000, 2'd1);
    addv(0, 4'b0111, c2, 0, 0, 8'h44, 3, 4'b0000, 4'b0000, 2'd0);
    addv(0, 4'b1111, c2, 0, 1, 8'h11, 0, 4'b0000, 4'b0000, 2'd2);
    addv(0, 4'b1111, c2, 1, 0, 8'h11, 0, 4'b0001, 4'b0000, 2'd1);
    addv(0, 4'b0000, c2, 0, 0, 8'h11, 0, 4'b0000, 4'b0000, 2'd0);

    do_reset();
    check_all("rst", 0, 8'h00, 0, 4'b0000, 4'b0000, 2'd0);

    foreach (tbl[i]) begin
      if (tbl[i].pre_rst) do_reset();
      SEND = tbl[i].send;
      CMD  = tbl[i].cmd;
      ACK  = tbl[i].ack;
      step();
      check_all($sformatf("v%0d", i), tbl[i].exp_ready, tbl[i].exp_cmd, tbl[i].exp_sel,
                tbl[i].exp_done, tbl[i].exp_tmo, tbl[i].exp_st);
    end

    // Timeout on ch2: READY lasts exactly TIMEOUT cycles
    do_reset();
    SEND = 4'b0100;
    CMD  = 32'h005C_0000;
    step();
    check_all("tmo_grant", 1, 8'h5C, 2, 4'b0000, 4'b0000, 2'd2);
    cnt = 1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (READY) cnt++;
      else break;
    end
    check("tmo_ready_len", 32'(cnt), 32'd20);
    check_all("tmo_end", 0, 8'h5C, 2, 4'b0000, 4'b0100, 2'd1);
    step();
    step();
    check_all("tmo_noretry", 0, 8'h5C, 2, 4'b0000, 4'b0100, 2'd0);
    SEND = 4'b0000;
    step();
    SEND = 4'b0100;
    step();
    check_all("tmo_regrant", 1, 8'h5C, 2, 4'b0000, 4'b0000, 2'd2);
    ACK = 1'b1;
    step();
    check_all("tmo_ack", 0, 8'h5C, 2, 4'b0100, 4'b0000, 2'd1);
    ACK  = 1'b0;
    SEND = 4'b0000;
    step();

    // ACK on the cycle the counter reaches TIMEOUT-1: ACK wins
    do_reset();
    SEND = 4'b0010;
    CMD  = 32'h0000_3C00;
    step();
    for (int k = 0; k < 19; k++) step();
    check_all("col_last", 1, 8'h3C, 1, 4'b0000, 4'b0000, 2'd2);
    ACK = 1'b1;
    step();
    check_all("col_ack", 0, 8'h3C, 1, 4'b0010, 4'b0000, 2'd1);
    ACK  = 1'b0;
    SEND = 4'b0000;
    step();

    // Inputs changing mid-READY are ignored; stray ACKs in IDLE do nothing
    do_reset();
    SEND = 4'b0010;
    CMD  = 32'h0000_7700;
    step();
    check_all("hold_grant", 1, 8'h77, 1, 4'b0000, 4'b0000, 2'd2);
    SEND = 4'b0000;
    CMD  = 32'h0000_EE00;
    step();
    step();
    check_all("hold_mid", 1, 8'h77, 1, 4'b0000, 4'b0000, 2'd2);
    ACK = 1'b1;
    step();
    check_all("hold_ack", 0, 8'h77, 1, 4'b0010, 4'b0000, 2'd1);
    ACK = 1'b0;
    step();
    ACK = 1'b1;
    step();
    check_all("stray1", 0, 8'h77, 1, 4'b0000, 4'b0000, 2'd0);
    step();
    check_all("stray2", 0, 8'h77, 1, 4'b0000, 4'b0000, 2'd0);
    ACK  = 1'b0;
    SEND = 4'b0010;
    step();
    check_all("rearm", 1, 8'hEE, 1, 4'b0000, 4'b0000, 2'd2);
    ACK = 1'b1;
    step();
    ACK  = 1'b0;
    SEND = 4'b0000;
    step();

    // Asynchronous reset during READY, and priority restored afterwards
    do_reset();
    SEND = 4'b0100;
    CMD  = 32'h0099_0000;
    step();
    check("arst_pre_ready", 32'(READY), 32'd1);
    RST = 1'b1;
    #1;
    check_all("arst_ready", 0, 8'h00, 0, 4'b0000, 4'b0000, 2'd0);
    @(posedge CLK);
    #1;
    RST  = 1'b0;
    SEND = 4'b1111;
    CMD  = c2;
    step();
    check_all("arst_prio", 1, 8'h11, 0, 4'b0000, 4'b0000, 2'd2);
    ACK = 1'b1;
    step();
    check("arst_pre_done", 32'(DONE), 32'h1);
    RST = 1'b1;
    #1;
    check("arst_done", 32'(DONE), 32'h0);
    @(posedge CLK);
    #1;
    RST  = 1'b0;
    ACK  = 1'b0;
    SEND = 4'b0001;
    CMD  = c1;
    step();
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (!READY) break;
      cnt++;
      step();
    end
    check("arst_tmo_len", 32'(cnt), 32'd20);
    check("arst_pre_tmo", 32'(TMO_ERR), 32'h1);
    RST = 1'b1;
    #1;
    check("arst_tmo", 32'(TMO_ERR), 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
